// File: rtl/x74xx259.sv
// 8-bit addressable latch (74xx259), fully synchronous to clock_50.
// Optional input register stage adds one cycle of latency.
module x74xx259 #(
    parameter logic [7:0] RESET_VALUE = 8'h00,
    parameter bit         INPUT_REG   = 1'b0
) (
    input  logic clock_50,
    input  logic reset,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic D,
    input  logic LE_N,
    input  logic MR_N,
    output logic Q0,
    output logic Q1,
    output logic Q2,
    output logic Q3,
    output logic Q4,
    output logic Q5,
    output logic Q6,
    output logic Q7
);

    logic [2:0] a_s;
    logic       d_s;
    logic       le_n_s;
    logic       mr_n_s;

    logic [7:0] q_q;
    logic [7:0] q_d;

    generate
        if (INPUT_REG) begin : g_inreg
            logic [2:0] a_q;
            logic       d_q;
            logic       le_n_q;
            logic       mr_n_q;

            // Idle tuple on reset so the first edge after release writes nothing
            always_ff @(posedge clock_50 or posedge reset) begin
                if (reset) begin
                    a_q    <= 3'd0;
                    d_q    <= 1'b0;
                    le_n_q <= 1'b1;
                    mr_n_q <= 1'b1;
                end else begin
                    a_q    <= {A2, A1, A0};
                    d_q    <= D;
                    le_n_q <= LE_N;
                    mr_n_q <= MR_N;
                end
            end

            assign a_s    = a_q;
            assign d_s    = d_q;
            assign le_n_s = le_n_q;
            assign mr_n_s = mr_n_q;
        end else begin : g_direct
            assign a_s    = {A2, A1, A0};
            assign d_s    = D;
            assign le_n_s = LE_N;
            assign mr_n_s = MR_N;
        end
    endgenerate

    always_comb begin
        q_d = q_q;
        unique case ({mr_n_s, le_n_s})
            2'b10: q_d[a_s] = d_s;
            2'b11: q_d = q_q;
            2'b00: begin
                q_d      = 8'h00;
                q_d[a_s] = d_s;
            end
            2'b01: q_d = 8'h00;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q0 = q_q[0];
    assign Q1 = q_q[1];
    assign Q2 = q_q[2];
    assign Q3 = q_q[3];
    assign Q4 = q_q[4];
    assign Q5 = q_q[5];
    assign Q6 = q_q[6];
    assign Q7 = q_q[7];

endmodule

// File: tb/tb_x74xx259.sv
// Directed bench for x74xx259: two instances (direct and registered inputs)
// share the pins; the registered one is expected to trail by one edge.
module tb_x74xx259;

    logic clk;
    logic reset;
    logic A0, A1, A2, D, LE_N, MR_N;
    logic [7:0] q0;
    logic [7:0] q1;
    logic [7:0] prev;
    logic [7:0] e;
    int n_asrt;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    x74xx259 #(.RESET_VALUE(8'hA5), .INPUT_REG(1'b0)) u_r0 (
        .clock_50(clk), .reset(reset),
        .A0(A0), .A1(A1), .A2(A2), .D(D), .LE_N(LE_N), .MR_N(MR_N),
        .Q0(q0[0]), .Q1(q0[1]), .Q2(q0[2]), .Q3(q0[3]),
        .Q4(q0[4]), .Q5(q0[5]), .Q6(q0[6]), .Q7(q0[7])
    );

    x74xx259 #(.RESET_VALUE(8'hA5), .INPUT_REG(1'b1)) u_r1 (
        .clock_50(clk), .reset(reset),
        .A0(A0), .A1(A1), .A2(A2), .D(D), .LE_N(LE_N), .MR_N(MR_N),
        .Q0(q1[0]), .Q1(q1[1]), .Q2(q1[2]), .Q3(q1[3]),
        .Q4(q1[4]), .Q5(q1[5]), .Q6(q1[6]), .Q7(q1[7])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a tuple, take one edge; direct copy must show exp, registered copy the previous exp
    task automatic step(input logic mr, input logic le, input logic [2:0] a,
                        input logic d, input logic [7:0] exp, input string tag);
        MR_N = mr;
        LE_N = le;
        {A2, A1, A0} = a;
        D = d;
        @(posedge clk);
        #1;
        chk({tag, "_r0"}, q0, exp);
        chk({tag, "_r1"}, q1, prev);
        prev = exp;
    endtask

    initial begin
        n_asrt = 0;
        n_fail = 0;
        reset = 1'b0;
        MR_N = 1'b1;
        LE_N = 1'b1;
        {A2, A1, A0} = 3'd0;
        D = 1'b0;

        // 1: async reset value before any clock edge, then hold in memory mode
        #1 reset = 1'b1;
        #1;
        chk("rst_async_r0", q0, 8'hA5);
        chk("rst_async_r1", q1, 8'hA5);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        prev = 8'hA5;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'd0, 1'b1, 8'hA5, "mem_hold");

        // 2: latch-mode walk, then clear bit 3
        step(1'b0, 1'b1, 3'd0, 1'b0, 8'h00, "clr_pre");
        e = 8'h00;
        for (int i = 0; i < 8; i++) begin
            e[i] = 1'b1;
            step(1'b1, 1'b0, 3'(i), 1'b1, e, "latch_walk");
        end
        step(1'b1, 1'b0, 3'd3, 1'b0, 8'hF7, "latch_d0_a3");
        step(1'b1, 1'b0, 3'd3, 1'b1, 8'hFF, "latch_d1_a3");

        // 3: demux mode
        step(1'b0, 1'b0, 3'd5, 1'b1, 8'h20, "demux_d1_a5");
        step(1'b0, 1'b0, 3'd5, 1'b0, 8'h00, "demux_d0_a5");

        // 4: build 5A, clear, then memory with D toggling
        step(1'b1, 1'b0, 3'd1, 1'b1, 8'h02, "build1");
        step(1'b1, 1'b0, 3'd3, 1'b1, 8'h0A, "build3");
        step(1'b1, 1'b0, 3'd4, 1'b1, 8'h1A, "build4");
        step(1'b1, 1'b0, 3'd6, 1'b1, 8'h5A, "build6");
        step(1'b0, 1'b1, 3'd6, 1'b1, 8'h00, "clear");
        step(1'b1, 1'b1, 3'd2, 1'b1, 8'h00, "mem_d1");
        step(1'b1, 1'b1, 3'd2, 1'b0, 8'h00, "mem_d0");
        step(1'b1, 1'b1, 3'd7, 1'b1, 8'h00, "mem_d1b");

        // 6: one-hot writes, each cleared again, to catch swapped pins
        for (int i = 0; i < 8; i++) begin
            e = 8'h01 << i;
            step(1'b1, 1'b0, 3'(i), 1'b1, e, "onehot_set");
            step(1'b1, 1'b0, 3'(i), 1'b0, 8'h00, "onehot_clr");
        end

        // 5: reset 3 ns after an edge carrying a write of 1 @7
        step(1'b1, 1'b0, 3'd7, 1'b1, 8'h80, "pre_rst_wr");
        #2 reset = 1'b1;
        MR_N = 1'b1;
        LE_N = 1'b1;
        #1;
        chk("rst_mid_r0", q0, 8'hA5);
        chk("rst_mid_r1", q1, 8'hA5);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        prev = 8'hA5;
        step(1'b1, 1'b1, 3'd0, 1'b0, 8'hA5, "post_rst");
        step(1'b1, 1'b1, 3'd0, 1'b0, 8'hA5, "post_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
